// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters; define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins)
module alu_arbiter #(
   parameter int DW = 32
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_req0_valid,
   input  logic [DW-1:0] i_req0_op_a,
   input  logic [DW-1:0] i_req0_op_b,
   input  logic [3:0]    i_req0_alu_op,
   input  logic          i_req1_valid,
   input  logic [DW-1:0] i_req1_op_a,
   input  logic [DW-1:0] i_req1_op_b,
   input  logic [3:0]    i_req1_alu_op,
   output logic          o_req0_ready,
   output logic          o_req1_ready,
   output logic [DW-1:0] o_alu_op_a,
   output logic [DW-1:0] o_alu_op_b,
   output logic [3:0]    o_alu_op,
   input  logic [DW-1:0] i_alu_data,
   output logic          o_rsp_valid,
   output logic          o_rsp_id,
   output logic [DW-1:0] o_rsp_data,
   input  logic          i_rsp_ready
);

   logic free;
   logic grant0;
   logic grant1;

   // The response slot can take a new result when empty or being drained this cycle.
   assign free = !o_rsp_valid || i_rsp_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
   // Port 0 always wins contention; readies are held low during reset.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (i_rst_n && free) begin
         grant0 = i_req0_valid;
         grant1 = i_req1_valid && !i_req0_valid;
      end
   end
`else
   logic last;

   // Round-robin: a lone requester wins; under contention the port that did not win last time wins.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (i_rst_n && free) begin
         if (i_req0_valid && i_req1_valid) begin
            grant0 = last;
            grant1 = !last;
         end else begin
            grant0 = i_req0_valid;
            grant1 = i_req1_valid;
         end
      end
   end

   // Last-winner pointer; reset to 1 so port 0 takes the first contention.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         last <= 1'b1;
      end else if (grant0 || grant1) begin
         last <= grant1;
      end
   end
`endif

   assign o_req0_ready = grant0;
   assign o_req1_ready = grant1;

   // Steer the granted port onto the ALU; idle cycles present zeros so the ALU inputs stay quiet.
   always_comb begin
      o_alu_op_a = '0;
      o_alu_op_b = '0;
      o_alu_op   = 4'd0;
      if (grant0) begin
         o_alu_op_a = i_req0_op_a;
         o_alu_op_b = i_req0_op_b;
         o_alu_op   = i_req0_alu_op;
      end else if (grant1) begin
         o_alu_op_a = i_req1_op_a;
         o_alu_op_b = i_req1_op_b;
         o_alu_op   = i_req1_alu_op;
      end
   end

   // Single-entry response register: load on transfer (overwriting a draining result), clear on drain.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_rsp_valid <= 1'b0;
         o_rsp_id    <= 1'b0;
         o_rsp_data  <= '0;
      end else if (grant0 || grant1) begin
         o_rsp_valid <= 1'b1;
         o_rsp_id    <= grant1;
         o_rsp_data  <= i_alu_data;
      end else if (i_rsp_ready) begin
         o_rsp_valid <= 1'b0;
      end
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` instance between two requesters: the core datapath (port 0) and an auxiliary unit such as an address generator or debug engine (port 1). It sits between the requesters and the ALU and drives the ALU operand and opcode inputs. The ALU result is captured into a single-entry response register with a valid/ready handshake. Arbitration is round-robin by default; fixed priority can be compiled in.

## Interface
Parameters:
- `DW`, default 32: operand and result width. Must equal the ALU width (32).

Ports:
- `i_clk`  in  1  single clock; all state updates on rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_req0_valid` / `i_req1_valid`  in  1  request pending on port 0 / port 1.
- `i_req0_op_a`, `i_req0_op_b` / `i_req1_op_a`, `i_req1_op_b`  in  DW  operands.
- `i_req0_alu_op` / `i_req1_alu_op`  in  4  ALU opcode (0 add … 9 sra; 10–15 yield 0).
- `o_req0_ready` / `o_req1_ready`  out  1  request accepted this cycle.
- `o_alu_op_a`, `o_alu_op_b`  out  DW  to ALU `i_op_a` / `i_op_b`.
- `o_alu_op`  out  4  to ALU `i_alu_op`.
- `i_alu_data`  in  DW  from ALU `o_alu_data` (combinational return).
- `o_rsp_valid`  out  1  response register holds a result.
- `o_rsp_id`  out  1  requester that owns the result (0/1).
- `o_rsp_data`  out  DW  registered ALU result.
- `i_rsp_ready`  in  1  consumer takes the response this cycle.

## Operation
- Slot free: `free = !o_rsp_valid || i_rsp_ready`.
- Grant is combinational, at most one port per cycle, and only when `free`. It is computed from the `valid` inputs and the last-winner pointer `last`.
- Only one valid: that port wins.
- Both valid: the port ≠ `last` wins.
- `o_reqN_ready = grantN`. A request transfers when `valid && ready`.
- ALU mux: when `grantN`, the ALU outputs carry port N's operands and opcode. With no grant they carry all zeros (op 0).
- On a transfer: `o_rsp_data <= i_alu_data`, `o_rsp_id <= N`, `o_rsp_valid <= 1`, `last <= N`.
- Drain without a new transfer (`o_rsp_valid && i_rsp_ready`): `o_rsp_valid <= 0`.
- Drain and transfer in the same cycle: the new result replaces the old one, and `o_rsp_valid` stays 1.
- Response stall (`o_rsp_valid && !i_rsp_ready`):
  - Both readies are 0.
  - `o_rsp_data` and `o_rsp_id` hold stable.
- Requesters must hold their operands and opcode stable while valid and not ready. The arbiter does not latch them.
- Opcodes 10–15 pass through unchanged; the result 0 is returned normally.
- Reset values:
  - `o_rsp_valid` = 0, `o_rsp_id` = 0, `o_rsp_data` = 0.
  - `last` = 1, so port 0 wins the first contention.
  - Readies are 0 while `i_rst_n` = 0.
- Reset mid-operation: a pending response is discarded, and requests presented in the reset cycle are not accepted.

## Timing
- Latency: a request accepted at edge T is presented as `o_rsp_valid` = 1 after edge T+1, with the result of the operands at T.
- Throughput: 1 result per cycle with `i_rsp_ready` held at 1. The two ports alternate under continuous contention.
- Starvation bound: a continuously valid port is granted within 2 free cycles.
- Combinational paths:
  - `valid` → `ready` → ALU mux → `i_alu_data` → D input of the response register.
  - `i_rsp_ready` → `o_reqN_ready`.
  - No path from `valid` to `o_rsp_*`.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - Defined: port 0 always wins contention. `last` is not implemented, and port 1 can starve.
  - Undefined (default): round-robin as above.
- Ports and latency are identical in both builds.

## Test plan
- Single request, port 0: add, a=5, b=7, `i_rsp_ready`=1 → `o_req0_ready`=1 at T; next cycle `o_rsp_valid`=1, `o_rsp_id`=0, `o_rsp_data`=12.
- Contention: both ports valid for 4 cycles (port 0 sub 10−3, port 1 xor 0xF0^0x0F), `i_rsp_ready`=1 → grants 0,1,0,1; responses 7, 0xFF, 7, 0xFF with ids 0,1,0,1.
- Backpressure: result 12 pending, `i_rsp_ready`=0 for 3 cycles with port 1 valid → readies 0; `o_rsp_data` holds 12. Then `i_rsp_ready`=1 → port 1 granted the same cycle, and its result appears next cycle with `o_rsp_valid` never dropping.
- Unused opcode: port 1 op 12, a=0xFFFFFFFF → `o_rsp_data`=0, `o_rsp_id`=1.
- Reset mid-stream: `i_rsp_ready`=0, response valid, `i_rst_n`=0 for 1 cycle with both ports valid → `o_rsp_valid`=0 and no ready asserted. After release, the first contention is granted to port 0.
- `ALU_ARB_FIXED_PRIO_EN` build: both ports valid for 3 cycles → port 0 granted every cycle, and `o_req1_ready` stays 0.
